// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Defining FIFO_RD_PARITY_EN adds a parity bit to each buffered beat.
package fifo_rd_pkg;

    localparam int DATA_W_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;

    // Beat-counter width; a single-beat burst still needs a one-bit counter.
    function automatic int cnt_width(input int burst_len);
        return (burst_len <= 2) ? 1 : $clog2(burst_len);
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Holding buffer for read-back bytes. Entry 0 is always the stream head, so the
// head data and valid come straight from registers.
module fifo_rd_skid #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic [OCC_W-1:0] occ,
    output logic             pop
);

    logic [WIDTH-1:0] ent_r  [DEPTH];
    logic [WIDTH-1:0] ent_nx [DEPTH];
    logic [DEPTH-1:0] vld_r;
    logic [DEPTH-1:0] vld_nx;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nx;
    logic [OCC_W-1:0] wr_idx_s;
    logic             pop_s;

    assign pop_s      = vld_r[0] & ready;
    assign pop        = pop_s;
    assign head_data  = ent_r[0];
    assign head_valid = vld_r[0];
    assign occ        = occ_r;

    // Shift toward the head on pop, then place a pushed entry just past the survivors.
    always_comb begin
        ent_nx   = ent_r;
        vld_nx   = vld_r;
        wr_idx_s = occ_r - OCC_W'(pop_s);
        occ_nx   = occ_r + OCC_W'(push) - OCC_W'(pop_s);
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_nx[i] = pop_s ? ent_r[i+1] : ent_r[i];
            vld_nx[i] = pop_s ? vld_r[i+1] : vld_r[i];
        end
        ent_nx[DEPTH-1] = pop_s ? {WIDTH{1'b0}} : ent_r[DEPTH-1];
        vld_nx[DEPTH-1] = pop_s ? 1'b0 : vld_r[DEPTH-1];
        for (int i = 0; i < DEPTH; i++) begin
            ent_nx[i] = (push && (OCC_W'(i) == wr_idx_s)) ? din : ent_nx[i];
            vld_nx[i] = (push && (OCC_W'(i) == wr_idx_s)) | vld_nx[i];
        end
    end

    // Buffer storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_r[i] <= {WIDTH{1'b0}};
            end
            vld_r <= {DEPTH{1'b0}};
            occ_r <= {OCC_W{1'b0}};
        end else begin
            ent_r <= ent_nx;
            vld_r <= vld_nx;
            occ_r <= occ_nx;
        end
    end

endmodule

// File: rtl/fifo_read_ctrl.sv
// Drain-side FIFO read controller: issues reads only when the skid buffer has room,
// and re-presents bytes as a framed valid/ready stream. Option: FIFO_RD_PARITY_EN.
module fifo_read_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DFLT,
    parameter int BURST_LEN  = 4,
    parameter int SKID_DEPTH = 2
) (
    input  logic              r_clk,
    input  logic              reset,
    input  logic              rd_enable,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
`ifdef FIFO_RD_PARITY_EN
    output logic              m_parity,
`endif
    output logic              busy
);

    localparam int CNT_W = cnt_width(BURST_LEN);
    localparam int OCC_W = $clog2(SKID_DEPTH + 1);
    localparam int SUM_W = OCC_W + 1;
`ifdef FIFO_RD_PARITY_EN
    localparam int ENT_W = DATA_W + 1;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`else
    localparam int ENT_W = DATA_W;
`endif

    rd_state_e        state_r;
    rd_state_e        state_nx;
    logic             inflight_r;
    logic [CNT_W-1:0] beat_cnt_r;
    logic             last_beat_s;
    logic             rd_en_s;
    logic [OCC_W-1:0] occ_s;
    logic             pop_s;
    logic             head_valid_s;
    logic [ENT_W-1:0] head_s;
    logic [ENT_W-1:0] push_din_s;

`ifdef FIFO_RD_PARITY_EN
    assign push_din_s = {calc_parity(fifo_data), fifo_data};
    assign m_parity   = head_s[DATA_W];
`else
    assign push_din_s = fifo_data;
`endif

    fifo_rd_skid #(
        .WIDTH (ENT_W),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk        (r_clk),
        .rst        (reset),
        .push       (inflight_r),
        .din        (push_din_s),
        .ready      (m_ready),
        .head_data  (head_s),
        .head_valid (head_valid_s),
        .occ        (occ_s),
        .pop        (pop_s)
    );

    // Count in-flight plus held bytes against the space a same-cycle pop frees.
    assign rd_en_s = (state_r == RUN) && !fifo_empty &&
                     ((SUM_W'(occ_s) + SUM_W'(inflight_r)) <
                      (SUM_W'(SKID_DEPTH) + SUM_W'(pop_s)));

    assign last_beat_s = (beat_cnt_r == CNT_W'(BURST_LEN - 1));
    assign fifo_r_en   = rd_en_s;
    assign m_data      = head_s[DATA_W-1:0];
    assign m_valid     = head_valid_s;
    assign m_last      = head_valid_s & last_beat_s;
    assign busy        = (state_r != IDLE);

    // Next-state logic; a reasserted rd_enable takes priority over finishing the drain.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            IDLE: begin
                if (rd_enable) state_nx = RUN;
                else           state_nx = IDLE;
            end
            RUN: begin
                if (!rd_enable) state_nx = DRAIN;
                else            state_nx = RUN;
            end
            DRAIN: begin
                if (rd_enable)                                     state_nx = RUN;
                else if (!inflight_r && (occ_s == {OCC_W{1'b0}})) state_nx = IDLE;
                else                                               state_nx = DRAIN;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register and one-cycle read-latency tracker.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_nx;
            inflight_r <= rd_en_s;
        end
    end

    // Burst framing counter advances only on accepted beats.
    always_ff @(posedge r_clk or posedge reset) begin
        if (reset) begin
            beat_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            beat_cnt_r <= last_beat_s ? {CNT_W{1'b0}} : (beat_cnt_r + CNT_W'(1));
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Scoreboard bench for fifo_read_ctrl with a queue-based FIFO model and random backpressure.
module tb_fifo_read_ctrl;

    localparam int BURST_LEN = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       last;
        logic       par;
    } exp_t;

    logic       r_clk = 1'b0;
    logic       reset;
    logic       rd_enable;
    logic       fifo_empty = 1'b1;
    logic       fifo_r_en;
    logic [7:0] fifo_data = 8'h00;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       m_last;
`ifdef FIFO_RD_PARITY_EN
    logic       m_parity;
`endif
    logic       busy;

    int         n_checks = 0;
    int         n_err    = 0;
    int         beat_k   = 0;
    int         rd_cnt   = 0;
    int         rd_base;
    logic       pend_rd  = 1'b0;
    logic [7:0] fifo_q [$];
    logic [7:0] load_q [$];
    exp_t       exp_q  [$];

    logic       prev_valid = 1'b0;
    logic       prev_acc   = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    logic       prev_last  = 1'b0;

    fifo_read_ctrl #(
        .DATA_W     (8),
        .BURST_LEN  (BURST_LEN),
        .SKID_DEPTH (2)
    ) dut (
        .r_clk      (r_clk),
        .reset      (reset),
        .rd_enable  (rd_enable),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
`ifdef FIFO_RD_PARITY_EN
        .m_parity   (m_parity),
`endif
        .busy       (busy)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // A byte enters the FIFO; its expected beat (framing by overall position) enters the scoreboard.
    task automatic load(input logic [7:0] b);
        exp_t e;
        e.d    = b;
        e.last = ((beat_k % BURST_LEN) == (BURST_LEN - 1));
        e.par  = (($countones(b) % 2) == 1);
        beat_k++;
        load_q.push_back(b);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        chk("drain_complete", exp_q.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_m_valid"},   m_valid,   0);
        chk({tag, "_m_data"},    m_data,    0);
        chk({tag, "_m_last"},    m_last,    0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_fifo_r_en"}, fifo_r_en, 0);
    endtask

    // FIFO model: one-cycle registered read data, zero when not reading.
    always begin
        @(posedge r_clk);
        #2;
        if (pend_rd) begin
            rd_cnt++;
            fifo_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'h00;
        end else begin
            fifo_data = 8'h00;
        end
        while (load_q.size() > 0) fifo_q.push_back(load_q.pop_front());
        fifo_empty = (fifo_q.size() == 0);
    end

    // Read-request sampling and the never-read-while-empty rule.
    always @(negedge r_clk) begin
        pend_rd = fifo_r_en;
        if (fifo_empty) chk("no_read_when_empty", fifo_r_en, 0);
    end

    // Stream monitor: beat stability and scoreboard comparison.
    always @(negedge r_clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end else begin
            if (prev_valid && !prev_acc) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data",  m_data,  prev_data);
                chk("hold_last",  m_last,  prev_last);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_beat: got data %0h, expected no beat", m_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", m_data, e.d);
                    chk("beat_last", m_last, e.last);
`ifdef FIFO_RD_PARITY_EN
                    chk("beat_parity", m_parity, e.par);
`endif
                end
            end
            prev_valid = m_valid;
            prev_data  = m_data;
            prev_last  = m_last;
            prev_acc   = m_valid && m_ready;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        rd_enable = 1'b0;
        m_ready   = 1'b1;
        repeat (2) tick();
        chk_reset_outputs("reset");

        // Preloaded burst at full rate.
        for (int b = 0; b < 8; b++) load(8'h11 + 8'(b));
        repeat (2) tick();
        reset     = 1'b0;
        rd_enable = 1'b1;
        @(negedge r_clk);
        chk("c0_fifo_r_en", fifo_r_en, 0);
        chk("c0_busy", busy, 0);
        @(negedge r_clk);
        chk("c1_fifo_r_en", fifo_r_en, 1);
        chk("c1_busy", busy, 1);
        @(negedge r_clk);
        chk("c2_m_valid", m_valid, 0);
        @(negedge r_clk);
        chk("c3_m_valid", m_valid, 1);
        chk("c3_m_data", m_data, 8'h11);
        for (int i = 0; i < 7; i++) begin
            @(negedge r_clk);
            chk("throughput_valid", m_valid, 1);
        end
        wait_drain(20);

        // Backpressure: only two reads may be outstanding.
        tick();
        m_ready = 1'b0;
        rd_base = rd_cnt;
        for (int b = 0; b < 8; b++) load(8'h11 + 8'(b));
        repeat (10) tick();
        @(negedge r_clk);
        chk("bp_reads_issued", rd_cnt - rd_base, 2);
        chk("bp_m_valid", m_valid, 1);
        chk("bp_m_data", m_data, 8'h11);
        tick();
        m_ready = 1'b1;
        wait_drain(40);

        // Empty gap inside a burst.
        tick();
        for (int b = 0; b < 3; b++) load(8'h21 + 8'(b));
        repeat (6) tick();
        for (int b = 0; b < 5; b++) load(8'h24 + 8'(b));
        wait_drain(40);

        // rd_enable drops with a read in flight.
        tick();
        load(8'hA5);
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (fifo_r_en) break;
        end
        chk("t4_read_seen", fifo_r_en, 1);
        tick();
        rd_enable = 1'b0;
        @(negedge r_clk);
        @(negedge r_clk);
        chk("t4_drain_busy", busy, 1);
        chk("t4_drain_valid", m_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge r_clk);
            if (!busy) break;
        end
        chk("t4_idle_busy", busy, 0);
        chk("t4_delivered", exp_q.size(), 0);
        tick();
        rd_base = rd_cnt;
        for (int b = 0; b < 3; b++) load(8'h51 + 8'(b));
        repeat (10) tick();
        chk("t4_no_reads_when_disabled", rd_cnt - rd_base, 0);
        rd_enable = 1'b1;
        wait_drain(40);

        // Reset with bytes buffered.
        tick();
        m_ready = 1'b0;
        load(8'h31);
        load(8'h32);
        repeat (6) tick();
        @(negedge r_clk);
        chk("t5_buffered_valid", m_valid, 1);
        tick();
        reset = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        exp_q.delete();
        beat_k = 0;
        for (int b = 0; b < 4; b++) load(8'h41 + 8'(b));
        repeat (2) tick();
        reset   = 1'b0;
        m_ready = 1'b1;
        wait_drain(40);

        // Random backpressure, enable toggling and sparse arrivals.
        for (int i = 0; i < 400; i++) begin
            m_ready   = ($urandom_range(0, 3) != 0);
            rd_enable = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 2) == 0) load(8'($urandom_range(0, 255)));
            tick();
        end
        rd_enable = 1'b1;
        m_ready   = 1'b1;
        wait_drain(400);

        // Parity patterns.
        load(8'h00);
        load(8'h01);
        load(8'hFF);
        load(8'h07);
        wait_drain(40);

        repeat (4) tick();
        chk("final_scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
